// File: rtl/edge_result_reader.sv
// ---------------------------------------------------------------------------
// edge_result_reader
//
// Walks an IMG_W x IMG_H frame in raster order and streams the composited
// Sobel result as a valid/ready byte stream. Each pixel is taken from:
//   - nothing (forced 8'h00) on row 0 or column 0, which the detector never
//     writes,
//   - the bounding-box BRAM when the pixel lies inside the box,
//   - the background BRAM otherwise.
//
// Ports
//   clka       single clock
//   reset      asynchronous, active-high reset
//   start      one-cycle pulse that begins a frame (only honoured when idle)
//   bg_en      background BRAM read enable
//   bg_addr    background address, row*IMG_W+col
//   bg_dout    background read data, one cycle after bg_en
//   bb_en      bounding-box BRAM read enable
//   bb_addr    bounding-box address, (row-Y0)*BBOX_W+(col-X0)
//   bb_dout    bounding-box read data, one cycle after bb_en
//   pix_data   output pixel
//   pix_valid  pix_data is valid
//   pix_ready  downstream accepts the pixel
//   pix_last   marks the final pixel of the frame
//   busy       frame in progress (STREAM or DRAIN)
//   done       one-cycle pulse after the last beat is accepted
//
// Pipeline: p0 = read issue (row/col counters, BRAM enables),
//           p1 = in-flight register (class + last flag while BRAM reads),
//           p2 = 2-entry output FIFO feeding the stream interface.
// ---------------------------------------------------------------------------
module edge_result_reader #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int BBOX_X0 = 106,
  parameter int BBOX_Y0 = 127,
  parameter int BBOX_X1 = 189,
  parameter int BBOX_Y1 = 169
) (
  input  logic        clka,
  input  logic        reset,
  input  logic        start,
  output logic        bg_en,
  output logic [15:0] bg_addr,
  input  logic [7:0]  bg_dout,
  output logic        bb_en,
  output logic [15:0] bb_addr,
  input  logic [7:0]  bb_dout,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        busy,
  output logic        done
);

  localparam int DATA_W = 8;
  localparam int BBOX_W = BBOX_X1 - BBOX_X0 + 1;

  localparam logic [7:0] COL_LAST = 8'(IMG_W - 1);
  localparam logic [7:0] ROW_LAST = 8'(IMG_H - 1);
  localparam logic [7:0] BB_X0    = 8'(BBOX_X0);
  localparam logic [7:0] BB_Y0    = 8'(BBOX_Y0);
  localparam logic [7:0] BB_X1    = 8'(BBOX_X1);
  localparam logic [7:0] BB_Y1    = 8'(BBOX_Y1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_BB,
    CLS_BG
  } cls_e;

  // Background address: full-width product, no truncation before the add.
  function automatic logic [15:0] calc_bg_addr(input logic [7:0] r,
                                               input logic [7:0] c);
    logic [15:0] row_base;
    row_base = 16'(r) * 16'(IMG_W);
    return row_base + {8'd0, c};
  endfunction

  // Bounding-box address. Offsets are only meaningful inside the box, where
  // r >= Y0 and c >= X0, so the 8-bit differences never wrap.
  function automatic logic [15:0] calc_bb_addr(input logic [7:0] r,
                                               input logic [7:0] c);
    logic [7:0]  dr;
    logic [7:0]  dc;
    logic [15:0] row_base;
    dr       = r - BB_Y0;
    dc       = c - BB_X0;
    row_base = 16'(dr) * 16'(BBOX_W);
    return row_base + {8'd0, dc};
  endfunction

  // Control state
  state_e      state_q, state_d;
  logic [7:0]  row_q, row_d;
  logic [7:0]  col_q, col_d;

  // In-flight register (p1)
  logic        vld_p1_q, vld_p1_d;
  cls_e        cls_p1_q, cls_p1_d;
  logic        last_p1_q, last_p1_d;

  // Output FIFO (p2)
  logic [1:0][DATA_W-1:0] fifo_data_q, fifo_data_d;
  logic [1:0]             fifo_last_q, fifo_last_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             fifo_cnt_q, fifo_cnt_d;

  // Combinational helpers
  logic              pop;
  logic              push;
  logic [2:0]        occ;
  logic              issue;
  logic              in_box;
  logic              is_last_pix;
  cls_e              pix_cls;
  logic [DATA_W-1:0] cap_data;

  // ---------------------------------------------------------------------
  // Stream interface: everything presented comes straight off the FIFO head.
  // Data and last are masked while empty so idle outputs read as zero.
  // ---------------------------------------------------------------------
  always_comb begin
    pix_valid = (fifo_cnt_q != 2'd0);
    pix_data  = pix_valid ? fifo_data_q[rd_ptr_q] : '0;
    pix_last  = pix_valid & fifo_last_q[rd_ptr_q];
    pop       = pix_valid & pix_ready;
    busy      = (state_q == S_STREAM) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
  end

  // ---------------------------------------------------------------------
  // p0: classify the current (row, col) and decide whether to issue.
  // occ is what the FIFO plus in-flight slot will hold next cycle without
  // a new issue; issuing only when that is below 2 means the pixel we start
  // now always has a FIFO slot when its data comes back.
  // ---------------------------------------------------------------------
  always_comb begin
    occ         = {1'b0, fifo_cnt_q} + {2'b00, vld_p1_q} - {2'b00, pop};
    issue       = (state_q == S_STREAM) && (occ < 3'd2);
    is_last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
    in_box      = (row_q >= BB_Y0) && (row_q <= BB_Y1) &&
                  (col_q >= BB_X0) && (col_q <= BB_X1);

    if ((row_q == 8'd0) || (col_q == 8'd0)) begin
      pix_cls = CLS_ZERO;
    end else if (in_box) begin
      pix_cls = CLS_BB;
    end else begin
      pix_cls = CLS_BG;
    end

    bg_en   = issue && (pix_cls == CLS_BG);
    bb_en   = issue && (pix_cls == CLS_BB);
    bg_addr = bg_en ? calc_bg_addr(row_q, col_q) : 16'd0;
    bb_addr = bb_en ? calc_bb_addr(row_q, col_q) : 16'd0;
  end

  // Raster counters: restart at (0,0) on an accepted start, advance per issue.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if ((state_q == S_IDLE) && start) begin
      row_d = 8'd0;
      col_d = 8'd0;
    end else if (issue) begin
      if (col_q == COL_LAST) begin
        col_d = 8'd0;
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  // Frame sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (issue && is_last_pix) state_d = S_DRAIN;
      S_DRAIN:  if (pop && pix_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // p1: remember what was issued while the BRAM read is outstanding.
  // ---------------------------------------------------------------------
  always_comb begin
    vld_p1_d  = issue;
    cls_p1_d  = pix_cls;
    last_p1_d = issue & is_last_pix;
  end

  // ---------------------------------------------------------------------
  // p2: pick the returned BRAM byte (or zero) and push it into the FIFO.
  // ---------------------------------------------------------------------
  always_comb begin
    case (cls_p1_q)
      CLS_BB:  cap_data = bb_dout;
      CLS_BG:  cap_data = bg_dout;
      default: cap_data = '0;
    endcase

    push        = vld_p1_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = cap_data;
      fifo_last_d[wr_ptr_q] = last_p1_q;
    end
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_q       <= 8'd0;
      col_q       <= 8'd0;
      vld_p1_q    <= 1'b0;
      cls_p1_q    <= CLS_ZERO;
      last_p1_q   <= 1'b0;
      fifo_last_q <= 2'b00;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      vld_p1_q    <= vld_p1_d;
      cls_p1_q    <= cls_p1_d;
      last_p1_q   <= last_p1_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // FIFO payload needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge clka) begin
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_edge_result_reader.sv
// ---------------------------------------------------------------------------
// tb_edge_result_reader
//
// Drives edge_result_reader with a reduced frame height (full 256-pixel row
// pitch, same bbox columns) so several complete frames fit in a short run.
// BRAMs are modelled with one-cycle read latency and return random garbage
// when not enabled. The expected stream is computed per pixel index from the
// compositing rules (border zero / bbox / background).
// ---------------------------------------------------------------------------
module tb_edge_result_reader;

  localparam int W    = 256;
  localparam int H    = 12;
  localparam int X0   = 106;
  localparam int Y0   = 3;
  localparam int X1   = 189;
  localparam int Y1   = 9;
  localparam int BW   = X1 - X0 + 1;
  localparam int NPIX = W * H;

  logic        clka = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pix_ready = 1'b0;
  logic        bg_en, bb_en;
  logic [15:0] bg_addr, bb_addr;
  logic [7:0]  bg_dout, bb_dout;
  logic [7:0]  pix_data;
  logic        pix_valid, pix_last, busy, done;

  int checks = 0;
  int errors = 0;

  edge_result_reader #(
    .IMG_W(W), .IMG_H(H),
    .BBOX_X0(X0), .BBOX_Y0(Y0), .BBOX_X1(X1), .BBOX_Y1(Y1)
  ) dut (
    .clka(clka), .reset(reset), .start(start),
    .bg_en(bg_en), .bg_addr(bg_addr), .bg_dout(bg_dout),
    .bb_en(bb_en), .bb_addr(bb_addr), .bb_dout(bb_dout),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .busy(busy), .done(done)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  // BRAM models
  logic [7:0] bg_mem [0:65535];
  logic [7:0] bb_mem [0:65535];
  always @(posedge clka) begin
    bg_dout <= bg_en ? bg_mem[bg_addr] : 8'($urandom);
    bb_dout <= bb_en ? bb_mem[bb_addr] : 8'($urandom);
  end

  // Reference model: 0 = zero border, 1 = bbox, 2 = background
  function automatic int cls_of(input int k);
    int r, c;
    r = k / W;
    c = k % W;
    if (r == 0 || c == 0) return 0;
    if (r >= Y0 && r <= Y1 && c >= X0 && c <= X1) return 1;
    return 2;
  endfunction

  function automatic logic [7:0] exp_pix(input int k);
    int r, c;
    r = k / W;
    c = k % W;
    case (cls_of(k))
      1:       return bb_mem[(r - Y0) * BW + (c - X0)];
      2:       return bg_mem[r * W + c];
      default: return 8'h00;
    endcase
  endfunction

  // Monitor
  logic        mon_clr = 1'b0;
  int          base = 0;
  int          beats, n_last, last_idx, last_cyc, first_valid;
  int          done_cnt, done_cyc, dual_en, stall_err, outstanding, max_out;
  logic        busy_at_done, busy_c1, prev_stall, prev_last;
  logic [7:0]  prev_data;
  logic [7:0]  got_data [0:NPIX-1];
  logic        got_last [0:NPIX-1];
  int          bg_q[$];
  int          bb_q[$];

  always @(negedge clka) begin
    if (mon_clr) begin
      beats <= 0; n_last <= 0; last_idx <= -1; last_cyc <= -1;
      first_valid <= -1; done_cnt <= 0; done_cyc <= -1;
      dual_en <= 0; stall_err <= 0; outstanding <= 0; max_out <= 0;
      busy_at_done <= 1'b1; busy_c1 <= 1'b0; prev_stall <= 1'b0;
      prev_last <= 1'b0; prev_data <= 8'h00;
      bg_q.delete();
      bb_q.delete();
      for (int k = 0; k < NPIX; k++) begin
        got_data[k] <= 8'hxx;
        got_last[k] <= 1'bx;
      end
    end else if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (bg_en && bb_en) dual_en <= dual_en + 1;
      if (bg_en) bg_q.push_back(int'(bg_addr));
      if (bb_en) bb_q.push_back(int'(bb_addr));
      if (cyc - base == 1) busy_c1 <= busy;
      if (pix_valid && first_valid < 0) first_valid <= cyc - base;
      if (prev_stall && !(pix_valid && pix_data === prev_data && pix_last === prev_last))
        stall_err <= stall_err + 1;
      prev_stall <= pix_valid && !pix_ready;
      prev_data  <= pix_data;
      prev_last  <= pix_last;
      if (pix_valid && pix_ready) begin
        if (beats < NPIX) begin
          got_data[beats] <= pix_data;
          got_last[beats] <= pix_last;
        end
        if (pix_last) begin
          n_last   <= n_last + 1;
          last_idx <= beats;
          last_cyc <= cyc - base;
        end
        beats <= beats + 1;
      end
      outstanding <= outstanding + int'(bg_en) + int'(bb_en)
                     - ((pix_valid && pix_ready && beats < NPIX && cls_of(beats) != 0) ? 1 : 0);
      if (outstanding > max_out) max_out <= outstanding;
      if (done) begin
        done_cnt     <= done_cnt + 1;
        done_cyc     <= cyc - base;
        busy_at_done <= busy;
      end
    end
  end

  function automatic int count_bad_beats(output int first_bad);
    int bad;
    bad = 0;
    first_bad = -1;
    for (int k = 0; k < NPIX; k++) begin
      if (got_data[k] !== exp_pix(k) || got_last[k] !== (k == NPIX - 1)) begin
        if (first_bad < 0) first_bad = k;
        bad++;
      end
    end
    return bad;
  endfunction

  function automatic int count_bad_addr();
    int bad, ig, ib, r, c;
    bad = 0; ig = 0; ib = 0;
    for (int k = 0; k < NPIX; k++) begin
      r = k / W;
      c = k % W;
      case (cls_of(k))
        1: begin
          if (ib >= bb_q.size() || bb_q[ib] != (r - Y0) * BW + (c - X0)) bad++;
          ib++;
        end
        2: begin
          if (ig >= bg_q.size() || bg_q[ig] != r * W + c) bad++;
          ig++;
        end
        default: ;
      endcase
    end
    if (ig != bg_q.size()) bad++;
    if (ib != bb_q.size()) bad++;
    return bad;
  endfunction

  // Runs one frame: reset pulse, start at edge 0, optional extra start pulses
  // in cycles rs1/rs2, optional reset assertion once abort_at beats are in.
  task automatic run_frame(input bit rand_rdy, input int rs1, input int rs2,
                           input int abort_at, output bit timed_out);
    bit seen_done;
    int cur;
    timed_out = 1'b0;
    seen_done = 1'b0;
    @(posedge clka); #1;
    reset = 1'b1; start = 1'b0; pix_ready = 1'b1;
    @(posedge clka); #1;
    reset = 1'b0; mon_clr = 1'b1;
    @(negedge clka);
    @(posedge clka); #1;
    mon_clr = 1'b0; base = cyc; start = 1'b1;
    for (int n = 0; n < 4 * NPIX + 200; n++) begin
      @(posedge clka); #1;
      cur = cyc - base;
      if (abort_at > 0 && beats >= abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        return;
      end
      start     = (cur == rs1) || (cur == rs2);
      pix_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clka);
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    if (!seen_done) timed_out = 1'b1;
    start = 1'b0;
    pix_ready = 1'b1;
    repeat (6) @(posedge clka);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clka);
    checks++; if (bg_en !== 1'b0) begin errors++; $display("FAIL reset_bg_en: got %b want 0", bg_en); end
    checks++; if (bb_en !== 1'b0) begin errors++; $display("FAIL reset_bb_en: got %b want 0", bb_en); end
    checks++; if (bg_addr !== 16'd0 || bb_addr !== 16'd0) begin errors++; $display("FAIL reset_addr: got %h/%h want 0", bg_addr, bb_addr); end
    checks++; if (pix_valid !== 1'b0 || pix_last !== 1'b0 || pix_data !== 8'h00) begin errors++; $display("FAIL reset_pix: got v=%b l=%b d=%h want 0", pix_valid, pix_last, pix_data); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b/%b want 0", busy, done); end
    // start together with reset: reset wins, nothing begins
    @(posedge clka); #1;
    start = 1'b1;
    @(posedge clka); #1;
    start = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clka);
    checks++; if (busy !== 1'b0 || pix_valid !== 1'b0 || bg_en !== 1'b0 || bb_en !== 1'b0) begin errors++; $display("FAIL reset_beats_start: got busy=%b valid=%b want 0", busy, pix_valid); end
  endtask

  task automatic test_full_frame();
    bit to;
    int nbad, fb;
    for (int a = 0; a < 65536; a++) begin
      bg_mem[a] = 8'(a);
      bb_mem[a] = 8'hA5;
    end
    run_frame(1'b0, -1, -1, 0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL full_timeout: got timeout want done"); end
    checks++; if (beats !== NPIX) begin errors++; $display("FAIL full_beats: got %0d want %0d", beats, NPIX); end
    nbad = count_bad_beats(fb);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL full_data: %0d bad beats, first %0d got %h want %h", nbad, fb, got_data[fb < 0 ? 0 : fb], exp_pix(fb < 0 ? 0 : fb)); end
    checks++; if (first_valid !== 3) begin errors++; $display("FAIL full_first_valid: got cycle %0d want 3", first_valid); end
    checks++; if (n_last !== 1 || last_idx !== NPIX - 1) begin errors++; $display("FAIL full_last: got %0d lasts at %0d want 1 at %0d", n_last, last_idx, NPIX - 1); end
    checks++; if (last_cyc !== NPIX + 2) begin errors++; $display("FAIL full_last_cycle: got %0d want %0d", last_cyc, NPIX + 2); end
    checks++; if (done_cnt !== 1 || done_cyc !== NPIX + 3) begin errors++; $display("FAIL full_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, NPIX + 3); end
    checks++; if (busy_c1 !== 1'b1 || busy_at_done !== 1'b0) begin errors++; $display("FAIL full_busy: got c1=%b at_done=%b want 1/0", busy_c1, busy_at_done); end
    checks++; if (dual_en !== 0 || max_out > 2) begin errors++; $display("FAIL full_enables: got dual=%0d max_out=%0d want 0 and <=2", dual_en, max_out); end
  endtask

  // Inspects the frame captured by test_full_frame.
  task automatic test_bbox_corners();
    int last_bb, found;
    last_bb = (bb_q.size() > 0) ? bb_q[bb_q.size() - 1] : -1;
    found = 0;
    foreach (bg_q[i]) if (bg_q[i] == (Y0 + 1) * W + X0 - 1) found++;
    checks++; if (bb_q.size() !== BW * (Y1 - Y0 + 1)) begin errors++; $display("FAIL bbox_reads: got %0d want %0d", bb_q.size(), BW * (Y1 - Y0 + 1)); end
    checks++; if ((bb_q.size() > 0 ? bb_q[0] : -1) !== 0) begin errors++; $display("FAIL bbox_first_addr: got %0d want 0", bb_q.size() > 0 ? bb_q[0] : -1); end
    checks++; if (last_bb !== (Y1 - Y0) * BW + BW - 1) begin errors++; $display("FAIL bbox_last_addr: got %0d want %0d", last_bb, (Y1 - Y0) * BW + BW - 1); end
    checks++; if (got_data[Y0 * W + X0] !== 8'hA5 || got_data[Y1 * W + X1] !== 8'hA5) begin errors++; $display("FAIL bbox_corner_data: got %h/%h want a5", got_data[Y0 * W + X0], got_data[Y1 * W + X1]); end
    checks++; if (found !== 1 || got_data[(Y0 + 1) * W + X0 - 1] !== 8'h69) begin errors++; $display("FAIL bbox_left_neighbour: got reads=%0d data=%h want 1/69", found, got_data[(Y0 + 1) * W + X0 - 1]); end
    checks++; if (count_bad_addr() !== 0) begin errors++; $display("FAIL bbox_addr_seq: got %0d bad addresses want 0", count_bad_addr()); end
  endtask

  task automatic test_border();
    int nz, bad_rd;
    nz = 0;
    bad_rd = 0;
    for (int k = 0; k < NPIX; k++)
      if ((k / W == 0 || k % W == 0) && got_data[k] !== 8'h00) nz++;
    foreach (bg_q[i]) if (bg_q[i] / W == 0 || bg_q[i] % W == 0) bad_rd++;
    checks++; if (nz !== 0) begin errors++; $display("FAIL border_data: got %0d nonzero border beats want 0", nz); end
    checks++; if (bad_rd !== 0) begin errors++; $display("FAIL border_reads: got %0d border bg reads want 0", bad_rd); end
    checks++; if ((bg_q.size() > 0 ? bg_q[0] : -1) !== W + 1) begin errors++; $display("FAIL border_first_bg: got %0d want %0d", bg_q.size() > 0 ? bg_q[0] : -1, W + 1); end
  endtask

  task automatic test_random_ready();
    bit to;
    int nbad, fb;
    for (int a = 0; a < 65536; a++) begin
      bg_mem[a] = 8'($urandom);
      bb_mem[a] = 8'($urandom);
    end
    run_frame(1'b1, -1, -1, 0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand_timeout: got timeout want done"); end
    checks++; if (beats !== NPIX) begin errors++; $display("FAIL rand_beats: got %0d want %0d", beats, NPIX); end
    nbad = count_bad_beats(fb);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL rand_data: %0d bad beats, first %0d got %h want %h", nbad, fb, got_data[fb < 0 ? 0 : fb], exp_pix(fb < 0 ? 0 : fb)); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL rand_stall_stable: got %0d changes want 0", stall_err); end
    checks++; if (max_out > 2 || dual_en !== 0) begin errors++; $display("FAIL rand_outstanding: got max=%0d dual=%0d want <=2/0", max_out, dual_en); end
    checks++; if (done_cnt !== 1 || n_last !== 1) begin errors++; $display("FAIL rand_done: got done=%0d last=%0d want 1/1", done_cnt, n_last); end
    checks++; if (count_bad_addr() !== 0) begin errors++; $display("FAIL rand_addr_seq: got %0d bad addresses want 0", count_bad_addr()); end
  endtask

  task automatic test_reset_midframe();
    bit to;
    int nbad, fb;
    run_frame(1'b0, -1, -1, 1000, to);
    @(negedge clka);
    checks++; if ({bg_en, bb_en, bg_addr, bb_addr, pix_data, pix_valid, pix_last, busy, done} !== '0) begin errors++; $display("FAIL abort_outputs: got busy=%b valid=%b bg_en=%b want all 0", busy, pix_valid, bg_en); end
    checks++; if (done_cnt !== 0 || beats < 1000 || beats > 1003) begin errors++; $display("FAIL abort_partial: got done=%0d beats=%0d want 0 and ~1000", done_cnt, beats); end
    repeat (3) @(posedge clka);
    run_frame(1'b0, -1, -1, 0, to);
    nbad = count_bad_beats(fb);
    checks++; if (to !== 1'b0 || beats !== NPIX || done_cnt !== 1) begin errors++; $display("FAIL abort_restart: got to=%b beats=%0d done=%0d want 0/%0d/1", to, beats, done_cnt, NPIX); end
    checks++; if (nbad !== 0 || first_valid !== 3) begin errors++; $display("FAIL abort_restart_data: got %0d bad, first valid %0d want 0/3", nbad, first_valid); end
  endtask

  task automatic test_restart_ignored();
    bit to;
    int nbad, fb;
    for (int a = 0; a < 65536; a++) bg_mem[a] = 8'($urandom);
    run_frame(1'b0, 10, 2000, 0, to);
    nbad = count_bad_beats(fb);
    checks++; if (to !== 1'b0 || beats !== NPIX) begin errors++; $display("FAIL restart_beats: got to=%b beats=%0d want 0/%0d", to, beats, NPIX); end
    checks++; if (done_cnt !== 1 || done_cyc !== NPIX + 3) begin errors++; $display("FAIL restart_done: got %0d at %0d want 1 at %0d", done_cnt, done_cyc, NPIX + 3); end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL restart_data: got %0d bad beats want 0", nbad); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_bbox_corners();
    test_border();
    test_random_ready();
    test_reset_midframe();
    test_restart_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_result_reader.md
# edge_result_reader

Read-back engine for the Sobel edge pipeline's result memories. On `start` it walks the full 256x256 frame in raster order. Each pixel comes from the background output BRAM, or from the bounding-box output BRAM when the pixel lies inside the box. Border pixels the detector never writes are forced to zero. The composited frame is emitted as a valid/ready byte stream for host upload or golden-image comparison.

## Interface
- `IMG_W`, 256, frame width; also the background BRAM row pitch.
- `IMG_H`, 256, frame height.
- `BBOX_X0`, 106, bounding-box left column (inclusive).
- `BBOX_Y0`, 127, bounding-box top row (inclusive).
- `BBOX_X1`, 189, bounding-box right column (inclusive).
- `BBOX_Y1`, 169, bounding-box bottom row (inclusive).
- `clka`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a frame; ignored unless IDLE.
- `bg_en`  out  1  background BRAM read enable.
- `bg_addr`  out  16  background address, row*IMG_W+col.
- `bg_dout`  in  8  background read data, valid 1 cycle after `bg_en`.
- `bb_en`  out  1  bbox BRAM read enable.
- `bb_addr`  out  16  bbox address, (row-BBOX_Y0)*BBOX_W+(col-BBOX_X0), where BBOX_W=X1-X0+1.
- `bb_dout`  in  8  bbox read data, valid 1 cycle after `bb_en`.
- `pix_data`  out  8  pixel value.
- `pix_valid`  out  1  `pix_data` is valid.
- `pix_ready`  in  1  downstream accepts the pixel.
- `pix_last`  out  1  marks pixel (IMG_H-1, IMG_W-1).
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States:
  - IDLE: `start` moves to STREAM.
  - STREAM: issues reads. When the read of the last pixel is issued, move to DRAIN.
  - DRAIN: when the `pix_last` beat is accepted, move to DONE.
  - DONE: pulse `done` and return to IDLE.
- Issue counters: `row` and `col`, 8 bits each, reset to 0 on `start`. `col` wraps at IMG_W-1 and increments `row`.
- Per issued pixel, classify it in the following order:
  - Zero: `row`==0, or `col`==0. No BRAM enable; the data is 8'h00.
  - Bbox: `row` is in [Y0,Y1] and `col` is in [X0,X1]. Assert `bb_en` and drive `bb_addr`.
  - Background: every other pixel. Assert `bg_en` and drive `bg_addr`.
- Only one enable is high per issue cycle. Both enables are low when nothing is issued.
- The classification and last flag travel in a 1-deep in-flight register. The next cycle captures the selected dout (or 0) into a 2-entry FIFO.
- Issue condition: state is STREAM and (fifo_count + inflight − pop) < 2, where pop = `pix_valid` & `pix_ready`. This sustains 1 pixel/cycle with `pix_ready` high and never overflows.
- `pix_data`, `pix_valid` and `pix_last` come from the FIFO head. Data and last are held stable while valid is high and ready is low.
- Arithmetic: the bbox address product uses at least 16 bits with no truncation. The maximum bbox address is 42*84+83 = 3611.
- `start` during STREAM, DRAIN or DONE has no effect.

## Timing
- Reset values: `bg_en`, `bb_en`, `pix_valid`, `pix_last`, `busy` and `done` are all 0. `bg_addr`, `bb_addr` and `pix_data` are 0. FIFO and in-flight register are empty. State is IDLE.
- Cycle numbering: `start` is sampled high at edge 0.
  - Cycle 1: first issue, pixel (0,0), zero class.
  - Cycle 2: data captured.
  - Cycle 3: `pix_valid` first high.
- Latency from issue to `pix_valid` is 2 cycles.
- With `pix_ready` held high, beat k is presented in cycle 3+k. `pix_last` is in cycle 65538; `done` is high in cycle 65539, and `busy` drops in the same cycle.
- Backpressure: with `pix_ready` low the FIFO fills to 2 and issue stops. Issue resumes in the cycle `pix_ready` returns.
- Asynchronous `reset` mid-frame: all state clears immediately. No `done` pulse is produced. The next `start` begins again at (0,0).
- Simultaneous `start` and `reset`: reset wins.

## Test plan
- Full frame, `pix_ready`=1, bg BRAM preloaded with (addr[7:0]) and bb BRAM with 8'hA5 → 65536 beats; first valid in cycle 3; `pix_last` only on beat 65535; one `done` pulse in cycle 65539.
- Bbox corners → pixel (127,106) reads `bb_addr`=0 and (169,189) reads `bb_addr`=3611, both returning 8'hA5; pixel (128,105) reads `bg_addr`=32873 and returns 8'h69.
- Border → every beat with row 0 or col 0 is 8'h00, with `bg_en`=`bb_en`=0 in its issue cycle; pixel (1,1) reads `bg_addr`=257.
- Random `pix_ready` (50% duty) → beat sequence identical to the first test; no duplicated or dropped beats; data stable while stalled; never more than 2 reads outstanding.
- `reset` asserted at beat 1000, then `start` → all outputs 0 during reset; the new frame restarts at (0,0) and `done` pulses exactly once.
- `start` re-pulsed at cycles 10 and 40000 → ignored; still exactly 65536 beats.
